banked_line_memory: RTL

- Instruction-driven line memory for the FMA data path.
- Generalises the single-address data cache:
  - line width derives from FMA_COUNT;
  - depth is parametric;
  - storage is split into WORDS = 3*FMA_COUNT word-wide column banks with per-word write enables, so immediates are written without read-modify-write;
  - LOADB/WRITEB may post-increment the address;
  - a ready handshake covers read latency.
- Sits between the instruction decoder and the FMA read/write buffers.

---
 rtl/banked_line_memory.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/banked_line_memory.sv
// Instruction-driven line memory: WORDS column banks with per-word write enables and a ready-gated read pipeline.
// Optional: define MEM_AUTO_INC_EN to enable reg_b[0] address post-increment on LOADB/WRITEB.
module banked_line_memory #(
  parameter int unsigned FMA_COUNT         = 2,
  parameter int unsigned WORD_WIDTH        = 16,
  parameter int unsigned LINE_WIDTH        = FMA_COUNT*3*WORD_WIDTH,
  parameter int unsigned DEPTH             = 384,
  parameter int unsigned ADDR_LENGTH       = $clog2(DEPTH),
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned READ_LATENCY      = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic [LINE_WIDTH-1:0]        buffer_read_in,
  output logic [LINE_WIDTH-1:0]        abc_out,
  output logic                         abc_valid_out,
  output logic                         err_out
);

  localparam int unsigned WORDS = 3*FMA_COUNT;
  localparam int unsigned CNT_W = $clog2(READ_LATENCY) + 1;

  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_LOADB  = 4'b1000;
  localparam logic [3:0] OP_WRITEB = 4'b1001;

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  abc_q, abc_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [WORDS-1:0]       we;
  logic [LINE_WIDTH-1:0]  wdata;
  logic [LINE_WIDTH-1:0]  mem_line;
  logic [LINE_WIDTH-1:0]  rd_line_q;
  logic                   rd_start;
  logic                   accept;

  logic [3:0]  opcode;
  logic [3:0]  reg_a;
  logic [15:0] imm;
  logic [3:0]  reg_b;
  logic        unused_bits;

  assign opcode      = instr_in[31:28];
  assign reg_a       = instr_in[27:24];
  assign imm         = instr_in[23:8];
  assign reg_b       = instr_in[7:4];
  assign unused_bits = ^{instr_in[7:0], reg_b};

  function automatic logic [ADDR_LENGTH-1:0] post_inc(input logic [ADDR_LENGTH-1:0] a,
                                                     input logic [3:0] rb);
`ifdef MEM_AUTO_INC_EN
    if (rb[0]) return (a == ADDR_LENGTH'(DEPTH-1)) ? '0 : a + ADDR_LENGTH'(1);
    return a;
`else
    return (rb == rb) ? a : a;
`endif
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    abc_d           = abc_q;
    valid_d         = 1'b0;
    err_d           = 1'b0;
    we              = '0;
    wdata           = buffer_read_in;
    rd_start        = 1'b0;
    instr_ready_out = (state_q == IDLE);
    accept          = instr_valid_in && instr_ready_out;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (opcode)
            OP_SMA: begin
              if (32'(imm) < DEPTH) addr_d = imm[ADDR_LENGTH-1:0];
              else                  err_d  = 1'b1;
            end
            OP_LOADI: begin
              // Immediate replicated across words; only the selected bank's enable fires.
              if (32'(reg_a) < WORDS) begin
                we    = WORDS'(1) << reg_a;
                wdata = {WORDS{WORD_WIDTH'(imm)}};
              end else begin
                err_d = 1'b1;
              end
            end
            OP_LOADB: begin
              we     = '1;
              addr_d = post_inc(addr_q, reg_b);
            end
            OP_WRITEB: begin
              rd_start = 1'b1;
              addr_d   = post_inc(addr_q, reg_b);
              if (READ_LATENCY == 1) begin
                abc_d   = mem_line;
                valid_d = 1'b1;
              end else begin
                state_d = READ_WAIT;
                cnt_d   = CNT_W'(READ_LATENCY-1);
              end
            end
            default: ;
          endcase
        end
      end
      READ_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          abc_d   = rd_line_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      abc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      abc_q   <= abc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally unreset so committed writes survive a reset.
  for (genvar w = 0; w < WORDS; w++) begin : g_bank
    logic [WORD_WIDTH-1:0] bank_q [DEPTH];

    always_ff @(posedge clk_in) begin
      if (we[w]) bank_q[addr_q] <= wdata[w*WORD_WIDTH +: WORD_WIDTH];
    end

    assign mem_line[w*WORD_WIDTH +: WORD_WIDTH] = bank_q[addr_q];
  end

  always_ff @(posedge clk_in) begin
    if (rd_start) rd_line_q <= mem_line;
  end

  assign abc_out       = abc_q;
  assign abc_valid_out = valid_q;
  assign err_out       = err_q;

endmodule
